// File: rtl/frame_buffer_write_ctrl.sv
// Moves captured pixels from the capture FIFO into one half of a ping-pong frame memory
// and hands completed frames to the display by swapping buffer ownership.
module frame_buffer_write_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  frame_start_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_o,
    output logic                  mem_we_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  disp_frame_done_i,
    output logic                  disp_buf_o,
    output logic                  wr_buf_o,
    output logic                  frame_done_o,
    output logic [7:0]            frame_drop_cnt_o,
    output logic                  short_frame_o
);

    localparam int                    FRAME_PIX  = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_WIDTH-1:0] FRAME_BASE = ADDR_WIDTH'(FRAME_PIX);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX   = ADDR_WIDTH'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pix_cnt;
    logic                  ready;
    logic                  pend_start;
    logic                  accept;
    logic                  swap;
    logic                  start;
    logic                  new_wr;

    function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic b);
        return b ? FRAME_BASE : '0;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign wr_buf_o   = ~disp_buf_o;
    assign mem_data_o = fifo_data_i;

    // Reset gates the IDLE drain so nothing is popped while the block is held in reset.
    always_comb begin
        mem_we_o  = 1'b0;
        fifo_rd_o = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE:    fifo_rd_o = !fifo_empty_i;
                WRITE: begin
                    mem_we_o  = !fifo_empty_i;
                    fifo_rd_o = !fifo_empty_i && mem_ready_i;
                end
                default: ;
            endcase
        end
        accept = mem_we_o && mem_ready_i;
        swap   = (state == IDLE) && disp_frame_done_i && ready;
        start  = frame_start_i || pend_start;
        new_wr = swap ? disp_buf_o : ~disp_buf_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            pix_cnt          <= '0;
            mem_addr_o       <= '0;
            ready            <= 1'b0;
            pend_start       <= 1'b0;
            disp_buf_o       <= 1'b0;
            frame_done_o     <= 1'b0;
            frame_drop_cnt_o <= 8'd0;
            short_frame_o    <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (swap) begin
                        disp_buf_o <= ~disp_buf_o;
                        ready      <= 1'b0;
                    end
                    if (start) begin
                        pend_start <= 1'b0;
                        pix_cnt    <= '0;
                        mem_addr_o <= buf_base(new_wr);
                        state      <= WRITE;
                        // A finished frame the display never claimed is overwritten.
                        if (ready && !swap) begin
                            ready            <= 1'b0;
                            frame_drop_cnt_o <= sat_inc(frame_drop_cnt_o);
                        end
                    end
                end
                WRITE: begin
                    if (frame_start_i) begin
                        pix_cnt          <= '0;
                        mem_addr_o       <= buf_base(wr_buf_o);
                        short_frame_o    <= 1'b1;
                        frame_drop_cnt_o <= sat_inc(frame_drop_cnt_o);
                    end else if (accept) begin
                        if (pix_cnt == LAST_PIX) begin
                            state        <= DONE;
                            frame_done_o <= 1'b1;
                        end else begin
                            pix_cnt    <= pix_cnt + ADDR_WIDTH'(1);
                            mem_addr_o <= mem_addr_o + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                    if (frame_start_i) pend_start <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_buffer_write_ctrl.md
Name: frame_buffer_write_ctrl

Overview:
Sequences captured camera pixels from the capture-side CDC FIFO (16-bit RGB565 words produced by the pixel capture block) into a double-buffered frame memory. Generates write addresses and tracks frames. Owns ping-pong buffer ownership between the capture writer and the HDMI display reader, so the display never reads a partially written frame. Sits between the pixel capture FIFO and the frame memory write port, in the clk_i domain.

Parameters:
DATA_WIDTH, 16, pixel word width (two OV5640 half-pixels)
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame
ADDR_WIDTH, 20, frame memory word address width; must hold 2*H_ACTIVE*V_ACTIVE

Ports:
clk_i  in  1  system clock; sole clock
rst_i  in  1  asynchronous, active-high reset
frame_start_i  in  1  single-cycle pulse, VSYNC falling edge already synchronised to clk_i
fifo_empty_i  in  1  capture FIFO empty (FIFO is first-word-fall-through)
fifo_data_i  in  DATA_WIDTH  FIFO head word, valid while !fifo_empty_i
fifo_rd_o  out  1  pop FIFO head this cycle
mem_we_o  out  1  write request
mem_ready_i  in  1  memory accepts write when mem_we_o && mem_ready_i
mem_addr_o  out  ADDR_WIDTH  write word address
mem_data_o  out  DATA_WIDTH  write data (= fifo_data_i)
disp_frame_done_i  in  1  single-cycle pulse, display finished reading a frame
disp_buf_o  out  1  buffer index the display reads
wr_buf_o  out  1  buffer index the writer targets; always ~disp_buf_o
frame_done_o  out  1  single-cycle pulse, full frame written
frame_drop_cnt_o  out  8  saturating count of dropped/overwritten/short frames
short_frame_o  out  1  sticky; set on any aborted frame, cleared only by reset

Behaviour:
- FRAME_PIX = H_ACTIVE*V_ACTIVE. Base address = wr_buf_o ? FRAME_PIX : 0. mem_addr_o = base + pix_cnt.
- Reset (async): state IDLE, disp_buf_o=0, wr_buf_o=1, pix_cnt=0, ready flag=0. All outputs 0 except wr_buf_o=1.
- States: IDLE, WRITE, DONE.
- IDLE:
  - mem_we_o=0.
  - fifo_rd_o = !fifo_empty_i; stale pixels are drained and discarded.
  - frame_start_i: pix_cnt<=0 and go to WRITE.
  - If ready=1 when frame_start_i arrives, the completed frame was never taken by the display. Clear ready and increment frame_drop_cnt_o.
- WRITE:
  - mem_we_o = !fifo_empty_i.
  - fifo_rd_o = mem_we_o && mem_ready_i, combinational, same cycle.
  - pix_cnt increments on each accepted write.
  - Accepted write with pix_cnt==FRAME_PIX-1: go to DONE.
  - frame_start_i in WRITE (short frame): restart at pix_cnt=0 in the same buffer, set short_frame_o, increment frame_drop_cnt_o. Same-cycle accepted write still completes at its old address.
- DONE (one cycle): frame_done_o=1, ready<=1, mem_we_o=0, go to IDLE. frame_start_i in this cycle is held and acted on in the IDLE cycle that follows.
- Swap rule:
  - disp_frame_done_i && ready && state==IDLE: disp_buf_o toggles, wr_buf_o toggles, ready<=0.
  - disp_frame_done_i otherwise: ignored; display re-reads the same buffer.
  - Swap and frame_start_i in the same IDLE cycle: swap takes effect first, no drop is counted, and the new frame's base uses the new wr_buf_o.
- Buffer indices never change during WRITE.
- frame_drop_cnt_o saturates at 255.
- No output has combinational dependence on disp_frame_done_i or frame_start_i.
- Latency: FIFO head appears on mem_data_o in the same cycle (combinational pass-through). Address registered from pix_cnt.

Test Plan:
(Bench uses H_ACTIVE=4, V_ACTIVE=2, FRAME_PIX=8.)
- Reset, frame_start_i, FIFO supplies 0x1000..0x1007, mem_ready_i=1 -> 8 writes at addr 8..15 with data 0x1000..0x1007; frame_done_o pulses 1 cycle after last write; wr_buf_o stays 1.
- After the first frame, pulse disp_frame_done_i in IDLE -> disp_buf_o=1, wr_buf_o=0; the next frame writes addr 0..7.
- mem_ready_i toggling 1,0,1,0 with a non-empty FIFO -> fifo_rd_o only on ready cycles; 8 pixels land at consecutive addresses; no data loss or duplication.
- frame_start_i after 5 accepted writes -> short_frame_o=1, frame_drop_cnt_o=1; next write goes to base+0; the completed frame has 8 correct words.
- Two full frames, no disp_frame_done_i -> frame_drop_cnt_o=1 at the second frame_start_i; disp_buf_o unchanged (0).
- frame_start_i and disp_frame_done_i in the same IDLE cycle with ready=1 -> swap occurs, frame_drop_cnt_o unchanged, writes target the new wr_buf_o base. Assert rst_i mid-WRITE -> all outputs return to reset values immediately.
